// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch redirect sequencer: resolves taken branches, pulses the PC
// redirect/flush controls and ignores wrong-path EX slots. Optional stats: BRANCH_STATS_EN.
module branch_redirect_ctrl #(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 2
`ifdef BRANCH_STATS_EN
   ,parameter int CNT_W       = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_cond_true,
    input  logic [XLEN-1:0] ex_target,
    input  logic            pipe_stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            pc_sel,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            squash_busy
`ifdef BRANCH_STATS_EN
   ,output logic [CNT_W-1:0] br_total_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    localparam logic [2:0] LP_DEPTH = 3'(FLUSH_DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;
    logic [XLEN-1:0] r_target;
    logic            r_pulse;
    logic            w_take;
    logic            w_capture;
    logic            w_fire;

    assign w_take = ex_valid & ex_is_branch & ex_cond_true;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_capture = 1'b1;
                    if (pipe_stall) begin
                        w_state_nxt = S_PEND;
                    end else begin
                        w_state_nxt = S_SQUASH;
                        w_cnt_nxt   = LP_DEPTH;
                        w_fire      = 1'b1;
                    end
                end
            end
            S_PEND: begin
                // Target was captured on entry; the re-presented branch is ignored.
                if (!pipe_stall) begin
                    w_state_nxt = S_SQUASH;
                    w_cnt_nxt   = LP_DEPTH;
                    w_fire      = 1'b1;
                end
            end
            S_SQUASH: begin
                if (!pipe_stall) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // NOTE: the target register is reset too, so a dropped pending branch
    // never leaks a stale redirect_pc after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_pulse  <= 1'b0;
            r_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_fire;
            if (w_capture) begin
                r_target <= ex_target;
            end
        end
    end

    assign redirect_valid = r_pulse;
    assign pc_sel         = r_pulse;
    assign flush_if_id    = r_pulse;
    assign flush_id_ex    = r_pulse;
    assign redirect_pc    = r_target;
    assign squash_busy    = (r_state != S_IDLE);

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             w_br_seen;
    logic             w_br_taken;
    logic             w_pend_go;

    // A stalled taken branch is counted once, on its PEND->SQUASH edge.
    assign w_pend_go  = (r_state == S_PEND) & ~pipe_stall;
    assign w_br_seen  = ((r_state == S_IDLE) & ex_valid & ex_is_branch & ~pipe_stall) | w_pend_go;
    assign w_br_taken = ((r_state == S_IDLE) & w_take & ~pipe_stall) | w_pend_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total_cnt <= '0;
            r_taken_cnt <= '0;
        end else begin
            if (w_br_seen && (r_total_cnt != '1)) begin
                r_total_cnt <= r_total_cnt + CNT_W'(1);
            end
            if (w_br_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign br_total_cnt = r_total_cnt;
    assign br_taken_cnt = r_taken_cnt;
`endif

endmodule
